march_bist_engine: RTL and testbench

Self-contained, parametrised memory BIST sequencer that runs March C- over one or more data backgrounds.
- Drives a single-port synchronous memory directly: address, write data, write enable, read enable, read data.
- Compares read data internally and reports done, a sticky fail flag and a saturating fail count.
- Next-generation replacement for the split controller / address-generator / data-generator / comparator BIST built around the memory block. Sits between a test-start source and one memory instance.

---
 rtl/march_bist_engine.sv | 214 +++++++++++++++++++++
 tb/tb_march_bist_engine.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/march_bist_engine.sv
// march_bist_engine: March C- memory BIST sequencer for one single-port
// synchronous memory, run over one or two data backgrounds
// (bg0 = all zeros, bg1 = checkerboard with bit i set for even i).
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   start         run request, accepted only in IDLE/DONE
//   mem_addr      memory address
//   mem_wdata     memory write data
//   mem_we        one-cycle write strobe
//   mem_re        one-cycle read strobe
//   mem_rdata     read data, valid READ_LAT cycles after mem_re
//   busy          run in progress
//   done          run finished, held until the next start or rst
//   fail          sticky miscompare flag for the current run
//   fail_count    saturating miscompare count for the current run
//
// Optional build macro BIST_FAIL_CAPTURE_EN adds fail_addr, fail_elem,
// fail_bg, fail_expected and fail_actual, which hold the first miscompare
// of a run.
module march_bist_engine #(
  parameter int a_width    = 4,
  parameter int width      = 4,
  parameter int READ_LAT   = 1,
  parameter int NUM_BG     = 1,
  parameter int FAIL_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [a_width-1:0]    mem_addr,
  output logic [width-1:0]      mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [width-1:0]      mem_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
`ifdef BIST_FAIL_CAPTURE_EN
  output logic [a_width-1:0]    fail_addr,
  output logic [2:0]            fail_elem,
  output logic                  fail_bg,
  output logic [width-1:0]      fail_expected,
  output logic [width-1:0]      fail_actual,
`endif
  output logic [FAIL_CNT_W-1:0] fail_count
);

  typedef enum logic [1:0] {IDLE, OP, RD_WAIT, DONE} state_t;

  function automatic logic [width-1:0] checker_pat();
    logic [width-1:0] p;
    p = '0;
    for (int unsigned i = 0; i < width; i += 2) p[i] = 1'b1;
    return p;
  endfunction

  localparam logic [width-1:0]   CHECKER   = checker_pat();
  localparam logic [a_width-1:0] ADDR_MAX  = '1;
  localparam logic               LAST_BG   = (NUM_BG > 1);
  localparam logic [1:0]         WAIT_LAST = 2'(READ_LAT - 1);

  // Data for an op: write data for writes, expected data for reads.
  function automatic logic [width-1:0] op_data(input logic bg, input logic [2:0] elem,
                                               input logic rd);
    logic [width-1:0] pat;
    logic             inv;
    pat = bg ? CHECKER : '0;
    inv = rd ? (elem == 3'd2 || elem == 3'd4) : (elem == 3'd1 || elem == 3'd3);
    return inv ? ~pat : pat;
  endfunction

  state_t           state;
  logic             bg_q;
  logic [2:0]       elem_q;
  logic             op_q;      // 0 = first op of the element, 1 = trailing write
  logic [1:0]       wait_q;
  logic [width-1:0] exp_q;

  logic             elem_down;
  logic             step;
  logic             run_end;
  logic             nxt_bg;
  logic [2:0]       nxt_elem;
  logic             nxt_op;
  logic [a_width-1:0] nxt_addr;
  logic             nxt_rd;
  logic [width-1:0] nxt_data;

  // Position of the op that follows the current one; mem_addr doubles as
  // the address counter so the driven address is always the march position.
  always_comb begin
    elem_down = (elem_q == 3'd3 || elem_q == 3'd4);
    step      = (state == OP && !mem_re) || (state == RD_WAIT && wait_q == WAIT_LAST);
    nxt_bg    = bg_q;
    nxt_elem  = elem_q;
    nxt_op    = 1'b0;
    nxt_addr  = mem_addr;
    run_end   = 1'b0;
    if (!op_q && elem_q != 3'd0 && elem_q != 3'd5) begin
      nxt_op = 1'b1;
    end else if (mem_addr != (elem_down ? '0 : ADDR_MAX)) begin
      nxt_addr = elem_down ? mem_addr - a_width'(1) : mem_addr + a_width'(1);
    end else if (elem_q != 3'd5) begin
      nxt_elem = elem_q + 3'd1;
      nxt_addr = (elem_q == 3'd2 || elem_q == 3'd3) ? ADDR_MAX : '0;
    end else if (bg_q != LAST_BG) begin
      nxt_bg   = 1'b1;
      nxt_elem = 3'd0;
      nxt_addr = '0;
    end else begin
      run_end = 1'b1;
    end
    nxt_rd   = !nxt_op && nxt_elem != 3'd0;
    nxt_data = op_data(nxt_bg, nxt_elem, nxt_rd);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      mem_re     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fail       <= 1'b0;
      fail_count <= '0;
      bg_q       <= 1'b0;
      elem_q     <= '0;
      op_q       <= 1'b0;
      wait_q     <= '0;
      exp_q      <= '0;
`ifdef BIST_FAIL_CAPTURE_EN
      fail_addr     <= '0;
      fail_elem     <= '0;
      fail_bg       <= 1'b0;
      fail_expected <= '0;
      fail_actual   <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      mem_re <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= OP;
            busy       <= 1'b1;
            done       <= 1'b0;
            fail       <= 1'b0;
            fail_count <= '0;
            bg_q       <= 1'b0;
            elem_q     <= '0;
            op_q       <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_we     <= 1'b1;
            exp_q      <= '0;
`ifdef BIST_FAIL_CAPTURE_EN
            fail_addr     <= '0;
            fail_elem     <= '0;
            fail_bg       <= 1'b0;
            fail_expected <= '0;
            fail_actual   <= '0;
`endif
          end
        end
        OP: begin
          if (mem_re) begin
            state  <= RD_WAIT;
            wait_q <= '0;
          end
        end
        RD_WAIT: begin
          wait_q <= wait_q + 2'd1;
          if (wait_q == WAIT_LAST && mem_rdata != exp_q) begin
            fail <= 1'b1;
            if (fail_count != '1) fail_count <= fail_count + FAIL_CNT_W'(1);
`ifdef BIST_FAIL_CAPTURE_EN
            if (!fail) begin
              fail_addr     <= mem_addr;
              fail_elem     <= elem_q;
              fail_bg       <= bg_q;
              fail_expected <= exp_q;
              fail_actual   <= mem_rdata;
            end
`endif
          end
        end
        default: state <= IDLE;
      endcase

      // Writes and completed reads share one advance path.
      if (step) begin
        if (run_end) begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end else begin
          state    <= OP;
          bg_q     <= nxt_bg;
          elem_q   <= nxt_elem;
          op_q     <= nxt_op;
          mem_addr <= nxt_addr;
          mem_we   <= !nxt_rd;
          mem_re   <= nxt_rd;
          exp_q    <= nxt_data;
          if (!nxt_rd) mem_wdata <= nxt_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_march_bist_engine.sv
// tb_march_bist_engine: two engine instances (defaults, and NUM_BG=2 /
// READ_LAT=2 / FAIL_CNT_W=2), each on its own behavioural memory with
// injectable faults, checked against a table-driven March C- model.
module tb_march_bist_engine;
  localparam int DEPTH = 16;
  localparam int RL_A = 1, BG_A = 1, FC_A = 8;
  localparam int RL_B = 2, BG_B = 2, FC_B = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic       rst_a, start_a, we_a, re_a, busy_a, done_a, fail_a;
  logic [3:0] addr_a, wdata_a, rdata_a;
  logic [7:0] fcnt_a;
  logic       rst_b, start_b, we_b, re_b, busy_b, done_b, fail_b;
  logic [3:0] addr_b, wdata_b, rdata_b;
  logic [1:0] fcnt_b;
`ifdef BIST_FAIL_CAPTURE_EN
  logic [3:0] fa_addr_a, fa_exp_a, fa_act_a, fa_addr_b, fa_exp_b, fa_act_b;
  logic [2:0] fa_elem_a, fa_elem_b;
  logic       fa_bg_a, fa_bg_b;
`endif

  march_bist_engine #(.a_width(4), .width(4), .READ_LAT(RL_A), .NUM_BG(BG_A),
                      .FAIL_CNT_W(FC_A)) u_a (
    .clk(clk), .rst(rst_a), .start(start_a), .mem_addr(addr_a), .mem_wdata(wdata_a),
    .mem_we(we_a), .mem_re(re_a), .mem_rdata(rdata_a), .busy(busy_a), .done(done_a),
    .fail(fail_a),
`ifdef BIST_FAIL_CAPTURE_EN
    .fail_addr(fa_addr_a), .fail_elem(fa_elem_a), .fail_bg(fa_bg_a),
    .fail_expected(fa_exp_a), .fail_actual(fa_act_a),
`endif
    .fail_count(fcnt_a));

  march_bist_engine #(.a_width(4), .width(4), .READ_LAT(RL_B), .NUM_BG(BG_B),
                      .FAIL_CNT_W(FC_B)) u_b (
    .clk(clk), .rst(rst_b), .start(start_b), .mem_addr(addr_b), .mem_wdata(wdata_b),
    .mem_we(we_b), .mem_re(re_b), .mem_rdata(rdata_b), .busy(busy_b), .done(done_b),
    .fail(fail_b),
`ifdef BIST_FAIL_CAPTURE_EN
    .fail_addr(fa_addr_b), .fail_elem(fa_elem_b), .fail_bg(fa_bg_b),
    .fail_expected(fa_exp_b), .fail_actual(fa_act_b),
`endif
    .fail_count(fcnt_b));

  // Fault configuration per memory (0 = a, 1 = b)
  logic [3:0] f_addr [2];
  logic [3:0] f_mask [2];
  logic [3:0] f_val  [2];
  logic       f_all  [2];

  function automatic logic [3:0] read_val(input int k, input logic [3:0] a, input logic [3:0] d);
    if (f_all[k]) return 4'hF;
    if (a == f_addr[k]) return (d & ~f_mask[k]) | (f_val[k] & f_mask[k]);
    return d;
  endfunction

  // Memories: read data is garbage except READ_LAT cycles after a read.
  logic [3:0] mem_a [DEPTH];
  logic [3:0] pipe_a [RL_A];
  logic [3:0] mem_b [DEPTH];
  logic [3:0] pipe_b [RL_B];
  always @(posedge clk) begin
    if (we_a) mem_a[addr_a] <= wdata_a;
    pipe_a[0] <= re_a ? read_val(0, addr_a, mem_a[addr_a]) : 4'($urandom);
    for (int i = 1; i < RL_A; i++) pipe_a[i] <= pipe_a[i-1];
  end
  always @(posedge clk) begin
    if (we_b) mem_b[addr_b] <= wdata_b;
    pipe_b[0] <= re_b ? read_val(1, addr_b, mem_b[addr_b]) : 4'($urandom);
    for (int i = 1; i < RL_B; i++) pipe_b[i] <= pipe_b[i-1];
  end
  assign rdata_a = pipe_a[RL_A-1];
  assign rdata_b = pipe_b[RL_B-1];

  // Op logs {is_read, addr, wdata}, busy cycle and strobe-rule violation counts
  logic [8:0] log_a [512];
  logic [8:0] log_b [512];
  int n_a = 0, cyc_a = 0, viol_a = 0;
  int n_b = 0, cyc_b = 0, viol_b = 0;
  always @(posedge clk) begin
    if (!rst_a && start_a && !busy_a) begin
      n_a <= 0; cyc_a <= 0; viol_a <= 0;
    end else begin
      if (busy_a) cyc_a <= cyc_a + 1;
      if ((we_a && re_a) || (!busy_a && (we_a || re_a))) viol_a <= viol_a + 1;
      if (we_a || re_a) begin
        if (n_a < 512) log_a[n_a] <= {re_a, addr_a, re_a ? 4'h0 : wdata_a};
        n_a <= n_a + 1;
      end
    end
  end
  always @(posedge clk) begin
    if (!rst_b && start_b && !busy_b) begin
      n_b <= 0; cyc_b <= 0; viol_b <= 0;
    end else begin
      if (busy_b) cyc_b <= cyc_b + 1;
      if ((we_b && re_b) || (!busy_b && (we_b || re_b))) viol_b <= viol_b + 1;
      if (we_b || re_b) begin
        if (n_b < 512) log_b[n_b] <= {re_b, addr_b, re_b ? 4'h0 : wdata_b};
        n_b <= n_b + 1;
      end
    end
  end

  // Reference: March C- as a table walked over a plain array.
  logic [8:0] exp_op [512];
  int         exp_n, exp_fails, ef_elem, ef_bg;
  logic [3:0] ef_addr, ef_exp, ef_act;

  task automatic model(input int k, input int nbg);
    logic [3:0] m [DEPTH];
    logic [3:0] pat, rv, wv, act;
    int a;
    exp_n = 0; exp_fails = 0; ef_elem = 0; ef_bg = 0;
    ef_addr = 4'h0; ef_exp = 4'h0; ef_act = 4'h0;
    for (int i = 0; i < DEPTH; i++) m[i] = 4'h0;
    for (int bg = 0; bg < nbg; bg++) begin
      pat = 4'h0;
      if (bg == 1) for (int i = 0; i < 4; i += 2) pat[i] = 1'b1;
      for (int e = 0; e < 6; e++) begin
        for (int j = 0; j < DEPTH; j++) begin
          a = (e == 3 || e == 4) ? DEPTH - 1 - j : j;
          if (e != 0) begin
            rv  = (e == 2 || e == 4) ? ~pat : pat;
            act = read_val(k, 4'(a), m[a]);
            exp_op[exp_n] = {1'b1, 4'(a), 4'h0};
            exp_n++;
            if (act != rv) begin
              if (exp_fails == 0) begin
                ef_addr = 4'(a); ef_elem = e; ef_bg = bg; ef_exp = rv; ef_act = act;
              end
              exp_fails++;
            end
          end
          if (e != 5) begin
            wv   = (e == 1 || e == 3) ? ~pat : pat;
            m[a] = wv;
            exp_op[exp_n] = {1'b0, 4'(a), wv};
            exp_n++;
          end
        end
      end
    end
  endtask

  task automatic set_start(input int k, input logic v);
    if (k == 0) start_a = v; else start_b = v;
  endtask

  task automatic clear_faults();
    for (int k = 0; k < 2; k++) begin
      f_addr[k] = 4'h0; f_mask[k] = 4'h0; f_val[k] = 4'h0; f_all[k] = 1'b0;
    end
  endtask

  task automatic wait_done(input int k);
    int budget;
    budget = (k == 0 ? BG_A * DEPTH * (10 + 5 * RL_A) : BG_B * DEPTH * (10 + 5 * RL_B)) + 20;
    for (int c = 0; c < budget && !(k == 0 ? done_a : done_b); c++) @(negedge clk);
  endtask

  task automatic check_run(input int k, input string tag);
    int nbg, rl, n, mism;
    longint sat;
    nbg  = (k == 0) ? BG_A : BG_B;
    rl   = (k == 0) ? RL_A : RL_B;
    sat  = (k == 0) ? 255 : 3;
    n    = (k == 0) ? n_a : n_b;
    mism = 0;
    model(k, nbg);
    check({tag, "_done"}, k == 0 ? done_a : done_b, 1);
    check({tag, "_busy"}, k == 0 ? busy_a : busy_b, 0);
    check({tag, "_len"}, k == 0 ? cyc_a : cyc_b, nbg * DEPTH * (10 + 5 * rl));
    check({tag, "_fail"}, k == 0 ? fail_a : fail_b, exp_fails != 0);
    check({tag, "_fcnt"}, k == 0 ? fcnt_a : fcnt_b, exp_fails > sat ? sat : exp_fails);
    check({tag, "_nops"}, n, exp_n);
    for (int i = 0; i < exp_n && i < n; i++)
      if ((k == 0 ? log_a[i] : log_b[i]) != exp_op[i]) mism++;
    check({tag, "_opseq"}, mism, 0);
    check({tag, "_strobe"}, k == 0 ? viol_a : viol_b, 0);
`ifdef BIST_FAIL_CAPTURE_EN
    check({tag, "_faddr"}, k == 0 ? fa_addr_a : fa_addr_b, ef_addr);
    check({tag, "_felem"}, k == 0 ? fa_elem_a : fa_elem_b, ef_elem);
    check({tag, "_fbg"},   k == 0 ? fa_bg_a : fa_bg_b, ef_bg);
    check({tag, "_fexp"},  k == 0 ? fa_exp_a : fa_exp_b, ef_exp);
    check({tag, "_fact"},  k == 0 ? fa_act_a : fa_act_b, ef_act);
`endif
  endtask

  task automatic do_run(input int k, input string tag, input bit hold);
    repeat ($urandom_range(0, 4)) @(negedge clk);
    set_start(k, 1'b1);
    @(negedge clk);
    if (!hold) set_start(k, 1'b0);
    wait_done(k);
    check_run(k, tag);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int good;
    rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
    clear_faults();
    repeat (3) @(negedge clk);
    check("rst_addr", addr_a, 0);   check("rst_wdata", wdata_a, 0);
    check("rst_we", we_a, 0);       check("rst_re", re_a, 0);
    check("rst_busy", busy_a, 0);   check("rst_done", done_a, 0);
    check("rst_fail", fail_a, 0);   check("rst_fcnt", fcnt_a, 0);
    check("rst_b_busy", busy_b, 0); check("rst_b_fcnt", fcnt_b, 0);
    rst_a = 1'b0; rst_b = 1'b0;

    // Fault-free, defaults: first 16 ops are ascending writes of zero
    do_run(0, "a_clean", 0);
    good = 0;
    for (int i = 0; i < 16; i++) if (log_a[i] == {1'b0, 4'(i), 4'h0}) good++;
    check("a_e0_writes", good, 16);

    // Fault-free, two backgrounds: E0 of bg1 writes the checkerboard
    do_run(1, "b_clean", 0);
    good = 0;
    for (int i = 0; i < 16; i++) if (log_b[160 + i] == {1'b0, 4'(i), 4'h5}) good++;
    check("b_bg1_e0", good, 16);

    // bit0 stuck-at-1 at address 5
    f_addr[0] = 4'd5; f_mask[0] = 4'h1; f_val[0] = 4'h1;
    do_run(0, "a_sa1", 0);
    check("a_sa1_cnt3", fcnt_a, 3);

    // Read data stuck at all-ones: counter saturates and holds
    f_all[1] = 1'b1;
    do_run(1, "b_sat", 0);
    check("b_sat_cnt", fcnt_b, 3);
    clear_faults();

    // Reset mid-run
    set_start(0, 1'b1); @(negedge clk); set_start(0, 1'b0);
    repeat (99) @(negedge clk);
    rst_a = 1'b1; @(negedge clk); rst_a = 1'b0;
    check("mid_rst_addr", addr_a, 0);  check("mid_rst_wdata", wdata_a, 0);
    check("mid_rst_we", we_a, 0);      check("mid_rst_re", re_a, 0);
    check("mid_rst_busy", busy_a, 0);  check("mid_rst_done", done_a, 0);
    check("mid_rst_fail", fail_a, 0);  check("mid_rst_fcnt", fcnt_a, 0);
    do_run(0, "a_after_rst", 0);

    // start held high: no restart while busy, restart from DONE clears status
    f_addr[0] = 4'd5; f_mask[0] = 4'h1; f_val[0] = 4'h1;
    do_run(0, "a_hold", 1);
    @(negedge clk);
    check("hold_restart_done", done_a, 0);
    check("hold_restart_busy", busy_a, 1);
    check("hold_restart_fail", fail_a, 0);
    check("hold_restart_fcnt", fcnt_a, 0);
    set_start(0, 1'b0);
    clear_faults();
    f_addr[0] = 4'd5; f_mask[0] = 4'h1; f_val[0] = 4'h1;
    wait_done(0);
    check_run(0, "a_hold2");
    clear_faults();

    // Randomized faults on either instance
    for (int r = 0; r < 8; r++) begin
      int k, mode;
      k    = $urandom_range(0, 1);
      mode = $urandom_range(0, 3);
      clear_faults();
      if (mode == 1 || mode == 2) begin
        f_addr[k] = 4'($urandom);
        f_mask[k] = 4'($urandom_range(1, 15));
        f_val[k]  = 4'($urandom);
      end else if (mode == 3) begin
        f_all[k] = 1'b1;
      end
      do_run(k, $sformatf("rnd%0d_k%0d_m%0d", r, k, mode), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
